// File: rtl/vertex_shader.sv
// Fetches the three vertex records of a face from vertex SRAM, applies the fixed-point
// viewport transform and holds the screen-space face with data_ready until consumed.
module vertex_shader #(
    parameter int                 SRAM_LAT = 2,
    parameter logic signed [15:0] SCALE_X  = 16'sd256,
    parameter logic signed [15:0] SCALE_Y  = 16'sd256,
    parameter int                 FRAC     = 8,
    parameter logic signed [12:0] X_OFF    = 13'sd320,
    parameter logic signed [12:0] Y_OFF    = 13'sd240,
    parameter logic [20:0]        DEPTH_B  = 21'd32768
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        vert_valid,
    input  logic [19:0] vert_index,
    output logic        sram_rd_en,
    output logic [19:0] sram_addr,
    input  logic [71:0] sram_rdata,
    input  logic        consume,
    output logic        data_ready,
    output logic [11:0] v1_x,
    output logic [11:0] v1_y,
    output logic [20:0] v1_depth,
    output logic [23:0] v1_color,
    output logic [11:0] v2_x,
    output logic [11:0] v2_y,
    output logic [20:0] v2_depth,
    output logic [23:0] v2_color,
    output logic [11:0] v3_x,
    output logic [11:0] v3_y,
    output logic [20:0] v3_depth,
    output logic [23:0] v3_color,
    output logic        protocol_err,
    output logic [1:0]  dbg_state
);
    // vert_valid/consume are single-cycle strobes with no backpressure: an index offered while
    // the block is busy is dropped and flagged; the SRAM side answers exactly SRAM_LAT cycles late.
    typedef enum logic [1:0] {S_COLLECT = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    state_t      state, state_nx;
    logic [1:0]  idx_cnt, fcnt, rd_tag;
    logic [19:0] slot [3];
    logic [SRAM_LAT-1:0] pv;
    logic [1:0]  pt [SRAM_LAT];
    logic [11:0] vx [3];
    logic [11:0] vy [3];
    logic [20:0] vd [3];
    logic [23:0] vc [3];

    logic        accept, drop, issue, last_wr, res_valid;
    logic [1:0]  accept_slot, issue_tag, res_tag;
    logic [11:0] tx, ty;
    logic [20:0] tdepth;

    function automatic logic [11:0] clamp12(input logic signed [32:0] v);
        if (v < 33'sd0)         return 12'd0;
        else if (v > 33'sd4095) return 12'hfff;
        else                    return v[11:0];
    endfunction

    function automatic logic [20:0] clamp21(input logic signed [22:0] v);
        if (v < 23'sd0)            return 21'd0;
        else if (v > 23'sd2097151) return 21'h1fffff;
        else                       return v[20:0];
    endfunction

    assign res_valid = pv[SRAM_LAT-1];
    assign res_tag   = pt[SRAM_LAT-1];
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!srst_n) state <= S_COLLECT;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_COLLECT: if (vert_valid && idx_cnt == 2'd2) state_nx = S_FETCH;
            S_FETCH:   if (fcnt == 2'd2) state_nx = S_DRAIN;
            S_DRAIN:   if (last_wr) state_nx = S_DONE;
            S_DONE:    if (consume) state_nx = S_COLLECT;
            default:   state_nx = S_COLLECT;
        endcase
    end

    // The first read is issued on the same edge that accepts the third index, so the three
    // strobes appear on the three cycles right after it.
    always_comb begin
        accept      = vert_valid && (state == S_COLLECT || (state == S_DONE && consume));
        accept_slot = (state == S_DONE) ? 2'd0 : idx_cnt;
        drop        = vert_valid && !accept;
        issue       = (state == S_COLLECT && vert_valid && idx_cnt == 2'd2) || state == S_FETCH;
        issue_tag   = (state == S_COLLECT) ? 2'd0 : fcnt;
        last_wr     = res_valid && res_tag == 2'd2 && state == S_DRAIN;
    end

    always_comb begin
        logic signed [15:0] rx, ry, rz;
        logic signed [31:0] prod_x, prod_y, px, py;
        logic signed [22:0] dz;
        rx     = sram_rdata[71:56];
        ry     = sram_rdata[55:40];
        rz     = sram_rdata[39:24];
        prod_x = 32'(rx) * 32'(SCALE_X);
        prod_y = 32'(ry) * 32'(SCALE_Y);
        px     = prod_x >>> FRAC;
        py     = prod_y >>> FRAC;
        tx     = clamp12(33'(px) + 33'(X_OFF));
        ty     = clamp12(33'(Y_OFF) - 33'(py));
        dz     = 23'(rz) + $signed({2'b00, DEPTH_B});
        tdepth = clamp21(dz);
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            idx_cnt      <= 2'd0;
            fcnt         <= 2'd0;
            sram_rd_en   <= 1'b0;
            sram_addr    <= 20'd0;
            rd_tag       <= 2'd0;
            pv           <= '0;
            data_ready   <= 1'b0;
            protocol_err <= 1'b0;
            for (int i = 0; i < SRAM_LAT; i++) pt[i] <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                slot[i] <= 20'd0;
                vx[i]   <= 12'd0;
                vy[i]   <= 12'd0;
                vd[i]   <= 21'd0;
                vc[i]   <= 24'd0;
            end
        end else begin
            if (accept) slot[accept_slot] <= vert_index;
            if (state == S_COLLECT && vert_valid)
                idx_cnt <= (idx_cnt == 2'd2) ? 2'd0 : idx_cnt + 2'd1;
            else if (state == S_DONE && consume)
                idx_cnt <= vert_valid ? 2'd1 : 2'd0;

            sram_rd_en <= issue;
            rd_tag     <= issue_tag;
            if (issue) begin
                sram_addr <= slot[issue_tag];
                fcnt      <= (issue_tag == 2'd2) ? 2'd0 : issue_tag + 2'd1;
            end

            pv[0] <= sram_rd_en;
            pt[0] <= rd_tag;
            for (int i = 1; i < SRAM_LAT; i++) begin
                pv[i] <= pv[i-1];
                pt[i] <= pt[i-1];
            end

            if (res_valid) begin
                vx[res_tag] <= tx;
                vy[res_tag] <= ty;
                vd[res_tag] <= tdepth;
                vc[res_tag] <= sram_rdata[23:0];
            end

            if (last_wr)                       data_ready <= 1'b1;
            else if (state == S_DONE && consume) data_ready <= 1'b0;
            if (drop) protocol_err <= 1'b1;
        end
    end

    assign v1_x = vx[0];  assign v1_y = vy[0];  assign v1_depth = vd[0];  assign v1_color = vc[0];
    assign v2_x = vx[1];  assign v2_y = vy[1];  assign v2_depth = vd[1];  assign v2_color = vc[1];
    assign v3_x = vx[2];  assign v3_y = vy[2];  assign v3_depth = vd[2];  assign v3_color = vc[2];
endmodule

// File: tb/tb_vertex_shader.sv
// Directed bench for vertex_shader: a fixed-latency SRAM model plus hand-computed expectations.
module tb_vertex_shader;
    logic        clk = 1'b0;
    logic        srst_n, vert_valid, consume;
    logic [19:0] vert_index;
    logic        sram_rd_en;
    logic [19:0] sram_addr;
    logic [71:0] sram_rdata;
    logic        data_ready, protocol_err;
    logic [11:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
    logic [20:0] v1_depth, v2_depth, v3_depth;
    logic [23:0] v1_color, v2_color, v3_color;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [71:0] mem [16];
    logic [1:0]  rq_v;
    logic [3:0]  rq_a [2];

    always #5 clk = ~clk;

    vertex_shader dut (
        .clk(clk), .srst_n(srst_n), .vert_valid(vert_valid), .vert_index(vert_index),
        .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .consume(consume), .data_ready(data_ready),
        .v1_x(v1_x), .v1_y(v1_y), .v1_depth(v1_depth), .v1_color(v1_color),
        .v2_x(v2_x), .v2_y(v2_y), .v2_depth(v2_depth), .v2_color(v2_color),
        .v3_x(v3_x), .v3_y(v3_y), .v3_depth(v3_depth), .v3_color(v3_color),
        .protocol_err(protocol_err), .dbg_state(dbg_state)
    );

    // SRAM with two cycles of read latency
    always @(posedge clk) begin
        rq_v     <= {rq_v[0], sram_rd_en};
        rq_a[0]  <= sram_addr[3:0];
        rq_a[1]  <= rq_a[0];
    end
    assign sram_rdata = rq_v[1] ? mem[rq_a[1]] : 72'd0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 72'd0;
        mem[5]  = {16'h000A, 16'h0004, 16'hFF9C, 24'hFF0000};
        mem[9]  = {16'h8000, 16'h8000, 16'h7FFF, 24'h00FF00};
        mem[2]  = {16'h0064, 16'hFFCE, 16'h0000, 24'h0000FF};
        mem[7]  = {16'h0FA0, 16'h012C, 16'h8000, 24'h123456};
        mem[3]  = {16'hFFFB, 16'h0000, 16'h0001, 24'hABCDEF};
        mem[11] = {16'h0002, 16'h0001, 16'h0005, 24'h010203};
        rq_v = 2'b00; rq_a[0] = 4'd0; rq_a[1] = 4'd0;
        srst_n = 1'b0; vert_valid = 1'b0; vert_index = 20'd0; consume = 1'b0;

        repeat (3) tick;
        chk("rst_rd_en", 32'(sram_rd_en), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_perr", 32'(protocol_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_v3_depth", 32'(v3_depth), 32'd0);
        srst_n = 1'b1;
        tick;

        // basic face 5,9,2 back to back
        vert_valid = 1'b1; vert_index = 20'd5; tick;
        vert_index = 20'd9; tick;
        vert_index = 20'd2; tick;
        vert_valid = 1'b0;
        chk("b_rd1", 32'(sram_rd_en), 32'd1); chk("b_addr1", 32'(sram_addr), 32'd5);
        tick;
        chk("b_rd2", 32'(sram_rd_en), 32'd1); chk("b_addr2", 32'(sram_addr), 32'd9);
        tick;
        chk("b_rd3", 32'(sram_rd_en), 32'd1); chk("b_addr3", 32'(sram_addr), 32'd2);
        tick;
        chk("b_rd_off", 32'(sram_rd_en), 32'd0);
        tick;
        chk("b_ready_t5", 32'(data_ready), 32'd0);
        tick;
        chk("b_ready_t6", 32'(data_ready), 32'd1);
        chk("b_state_done", 32'(dbg_state), 32'd3);
        chk("b_v1_x", 32'(v1_x), 32'd330);
        chk("b_v1_y", 32'(v1_y), 32'd236);
        chk("b_v1_depth", 32'(v1_depth), 32'd32668);
        chk("b_v1_color", 32'(v1_color), 32'hFF0000);
        chk("clamp_v2_x", 32'(v2_x), 32'd0);
        chk("clamp_v2_y", 32'(v2_y), 32'd4095);
        chk("clamp_v2_depth", 32'(v2_depth), 32'd65535);
        chk("b_v3_x", 32'(v3_x), 32'd420);
        chk("b_v3_y", 32'(v3_y), 32'd290);
        chk("b_v3_depth", 32'(v3_depth), 32'd32768);
        chk("b_v3_color", 32'(v3_color), 32'h0000FF);

        // hold without consume
        repeat (20) tick;
        chk("h_ready", 32'(data_ready), 32'd1);
        chk("h_v1_x", 32'(v1_x), 32'd330);
        chk("h_v2_color", 32'(v2_color), 32'h00FF00);
        chk("h_perr", 32'(protocol_err), 32'd0);

        // consume with a new index in the same cycle, then gapped indices 3 and 11
        consume = 1'b1; vert_valid = 1'b1; vert_index = 20'd7; tick;
        consume = 1'b0; vert_valid = 1'b0;
        chk("c_ready", 32'(data_ready), 32'd0);
        chk("c_state", 32'(dbg_state), 32'd0);
        chk("c_v1_kept", 32'(v1_x), 32'd330);
        tick; tick;
        vert_valid = 1'b1; vert_index = 20'd3; tick;
        vert_valid = 1'b0; tick; tick;
        vert_valid = 1'b1; vert_index = 20'd11; tick;
        // index offered during FETCH must be dropped
        vert_index = 20'd5;
        chk("g_rd1", 32'(sram_rd_en), 32'd1); chk("g_addr1", 32'(sram_addr), 32'd7);
        chk("g_state_fetch", 32'(dbg_state), 32'd1);
        tick;
        vert_valid = 1'b0;
        chk("g_addr2", 32'(sram_addr), 32'd3);
        chk("p_perr", 32'(protocol_err), 32'd1);
        tick;
        chk("g_addr3", 32'(sram_addr), 32'd11);
        tick;
        chk("g_rd_off", 32'(sram_rd_en), 32'd0);
        chk("g_state_drain", 32'(dbg_state), 32'd2);
        consume = 1'b1;
        tick;
        consume = 1'b0;
        chk("g_ready_t5", 32'(data_ready), 32'd0);
        tick;
        chk("g_ready_t6", 32'(data_ready), 32'd1);
        chk("g_v1_x", 32'(v1_x), 32'd4095);
        chk("g_v1_y", 32'(v1_y), 32'd0);
        chk("g_v1_depth", 32'(v1_depth), 32'd0);
        chk("g_v1_color", 32'(v1_color), 32'h123456);
        chk("g_v2_x", 32'(v2_x), 32'd315);
        chk("g_v2_y", 32'(v2_y), 32'd240);
        chk("g_v2_depth", 32'(v2_depth), 32'd32769);
        chk("g_v3_x", 32'(v3_x), 32'd322);
        chk("g_v3_y", 32'(v3_y), 32'd239);
        chk("g_v3_depth", 32'(v3_depth), 32'd32773);

        consume = 1'b1; tick; consume = 1'b0;
        chk("c2_ready", 32'(data_ready), 32'd0);
        chk("c2_state", 32'(dbg_state), 32'd0);
        chk("c2_perr_sticky", 32'(protocol_err), 32'd1);

        // reset held three cycles in the middle of FETCH
        vert_valid = 1'b1; vert_index = 20'd5; tick;
        vert_index = 20'd9; tick;
        vert_index = 20'd2; tick;
        vert_valid = 1'b0;
        chk("r_rd1", 32'(sram_rd_en), 32'd1);
        srst_n = 1'b0;
        repeat (3) tick;
        chk("r_rd_en", 32'(sram_rd_en), 32'd0);
        chk("r_ready", 32'(data_ready), 32'd0);
        chk("r_perr", 32'(protocol_err), 32'd0);
        chk("r_state", 32'(dbg_state), 32'd0);
        chk("r_v1_x", 32'(v1_x), 32'd0);
        chk("r_v2_color", 32'(v2_color), 32'd0);
        srst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("r_post_rd_en", 32'(sram_rd_en), 32'd0);
            chk("r_post_ready", 32'(data_ready), 32'd0);
        end
        chk("r_post_v1_x", 32'(v1_x), 32'd0);
        chk("r_post_state", 32'(dbg_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
